// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the CRC frame serializer.
// Optional feature macro: CRC_ZERO_PAD_EN (16 zero bits appended after the data).
package crc_pkg;

    localparam int CRC_W    = 16;
    localparam int BYTE_W   = 8;
    localparam int PAD_BITS = 16;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_START = 3'd1;
    localparam state_t S_SHIFT = 3'd2;
    localparam state_t S_PAD   = 3'd3;
    localparam state_t S_WAIT  = 3'd4;

    // Bit counter must cover the longer of the data phase and the pad phase.
    function automatic int cnt_width(input int frame_bytes);
        int longest;
        longest = (BYTE_W * frame_bytes > PAD_BITS) ? BYTE_W * frame_bytes : PAD_BITS;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/crc_frame_serializer_byte_fifo.sv
// Synchronous byte FIFO with occupancy count, full and empty flags.
// Push into a full FIFO or pop from an empty one is ignored.
module byte_fifo
    import crc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/crc_frame_serializer.sv
// Buffers bytes, shifts each full frame MSB-first to a serial CRC engine, captures its remainder.
// Optional feature macro: CRC_ZERO_PAD_EN (append 16 zero bits after the frame data).
module crc_frame_serializer
    import crc_pkg::*;
#(
    parameter int FRAME_BYTES = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              crc_start,
    output logic              crc_data,
    input  logic              crc_done,
    input  logic [15:0]       crc_r,
    output logic [15:0]       result,
    output logic              result_valid,
    output logic              busy
);

    localparam int BW = cnt_width(FRAME_BYTES);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(BYTE_W * FRAME_BYTES - 1);
`ifdef CRC_ZERO_PAD_EN
    localparam logic [BW-1:0] LAST_PAD = BW'(PAD_BITS - 1);
`endif

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CRC_W-1:0]  result_q, result_d;
    logic              result_valid_q, result_valid_d;

    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_dout;
    logic [FW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              frame_ready;

    byte_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign frame_ready  = ~fifo_empty & (fifo_count >= FW'(FRAME_BYTES));
    assign in_ready     = ~fifo_full;
    assign crc_start    = (state_q == S_START);
    assign crc_data     = (state_q == S_SHIFT) & shreg_q[BYTE_W-1];
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        fifo_pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                fifo_pop  = 1'b1;
                shreg_d   = fifo_dout;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shreg_d   = {shreg_q[BYTE_W-2:0], 1'b0};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
`ifdef CRC_ZERO_PAD_EN
                    state_d   = S_PAD;
`else
                    state_d   = S_WAIT;
`endif
                end else if (bit_cnt_q[2:0] == 3'b111) begin
                    // Reload on the byte boundary so bits stay contiguous.
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                end
            end
`ifdef CRC_ZERO_PAD_EN
            S_PAD: begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_PAD) begin
                    bit_cnt_d = '0;
                    state_d   = S_WAIT;
                end
            end
`endif
            S_WAIT: begin
                if (crc_done) begin
                    result_d       = crc_r;
                    result_valid_d = 1'b1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Randomized self-checking bench for crc_frame_serializer against a queue-based frame model.
// Frame length follows CRC_ZERO_PAD_EN.
module tb_crc_frame_serializer;

    localparam int FB = 4;
`ifdef CRC_ZERO_PAD_EN
    localparam int FBITS = 8 * FB + 16;
`else
    localparam int FBITS = 8 * FB;
`endif

    logic        clock;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        crc_start;
    logic        crc_data;
    logic        crc_done;
    logic [15:0] crc_r;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;

    int errs   = 0;
    int checks = 0;
    logic [7:0]  byte_q[$];
    logic [15:0] last_result;

    crc_frame_serializer #(
        .FRAME_BYTES (FB),
        .FIFO_DEPTH  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .crc_start    (crc_start),
        .crc_data     (crc_data),
        .crc_done     (crc_done),
        .crc_r        (crc_r),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        crc_done = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_crc_start", crc_start, 0);
        chk("rst_crc_data", crc_data, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        byte_q.delete();
        last_result = 16'h0000;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("push_timeout", 1, 0);
        step();
        byte_q.push_back(b);
        in_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (crc_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("start_seen", crc_start, 1);
        step();
    endtask

    task automatic take_frame(output logic [FBITS-1:0] e);
        logic [7:0] b;
        e = '0;
        for (int j = 0; j < FB; j++) begin
            if (byte_q.size() == 0) begin
                chk("model_underrun", 0, 1);
                b = 8'h00;
            end else begin
                b = byte_q.pop_front();
            end
            e[FBITS-1-8*j -: 8] = b;
        end
    endtask

    task automatic shift_bits(input logic [FBITS-1:0] e, input int from, input int upto,
                              input int spur);
        for (int i = from; i < upto; i++) begin
            chk("bit", crc_data, e[FBITS-1-i]);
            chk("shift_busy", busy, 1);
            chk("shift_no_rv", result_valid, 0);
            if (i == spur) begin
                crc_done = 1'b1;
                crc_r    = 16'hDEAD;
            end else begin
                crc_done = 1'b0;
            end
            step();
        end
        crc_done = 1'b0;
    endtask

    task automatic finish_frame(input logic [15:0] crc, input int delay);
        chk("wait_data", crc_data, 0);
        chk("wait_busy", busy, 1);
        chk("result_hold", result, last_result);
        for (int k = 0; k < delay; k++) begin
            chk("wait_no_rv", result_valid, 0);
            step();
        end
        crc_done = 1'b1;
        crc_r    = crc;
        step();
        crc_done = 1'b0;
        crc_r    = 16'($urandom);
        chk("rv_pulse", result_valid, 1);
        chk("result", result, crc);
        chk("idle_busy", busy, 0);
        last_result = crc;
        step();
        chk("rv_single", result_valid, 0);
        chk("result_keep", result, crc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FBITS-1:0] e;
        logic [7:0]       b9;
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        crc_done = 1'b0;
        crc_r    = 16'h0000;
        last_result = 16'h0000;

        do_reset();
        push(8'h03);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("start_not_yet", crc_start, 0);
        step();
        chk("start_latency", crc_start, 1);
        chk("start_data", crc_data, 0);
        take_frame(e);
        step();
        shift_bits(e, 0, FBITS, -1);
        finish_frame(16'hBEEF, 2);

        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < FB; j++) begin
                repeat ($urandom_range(0, 2)) step();
                push(8'($urandom));
            end
            wait_start();
            take_frame(e);
            shift_bits(e, 0, FBITS, -1);
            finish_frame(16'($urandom), $urandom_range(0, 5));
        end

        for (int j = 0; j < FB; j++) push(8'($urandom));
        wait_start();
        take_frame(e);
        shift_bits(e, 0, FBITS, -1);
        for (int j = 0; j < 8; j++) push(8'($urandom));
        chk("full_ready_low", in_ready, 0);
        b9       = 8'($urandom);
        in_data  = b9;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("full_hold", in_ready, 0);
            step();
        end
        finish_frame(16'($urandom), 0);
        chk("next_start", crc_start, 1);
        chk("ready_before_pop", in_ready, 0);
        take_frame(e);
        step();
        chk("ready_after_pop", in_ready, 1);
        chk("bit", crc_data, e[FBITS-1]);
        step();
        byte_q.push_back(b9);
        in_valid = 1'b0;
        shift_bits(e, 1, FBITS, -1);
        finish_frame(16'($urandom), 1);
        wait_start();
        take_frame(e);
        shift_bits(e, 0, FBITS, -1);
        finish_frame(16'($urandom), 3);

        do_reset();
        for (int j = 0; j < FB - 1; j++) push(8'($urandom));
        for (int k = 0; k < 100; k++) begin
            chk("partial_no_start", crc_start, 0);
            chk("partial_idle", busy, 0);
            step();
        end
        push(8'($urandom));
        wait_start();
        take_frame(e);
        shift_bits(e, 0, FBITS, -1);
        finish_frame(16'($urandom), 2);

        for (int j = 0; j < FB; j++) push(8'($urandom));
        wait_start();
        take_frame(e);
        shift_bits(e, 0, 20, -1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        byte_q.delete();
        chk("abort_data", crc_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_result", result, 0);
        last_result = 16'h0000;
        for (int k = 0; k < 60; k++) begin
            crc_done = (k == 10);
            chk("abort_no_rv", result_valid, 0);
            chk("abort_no_start", crc_start, 0);
            step();
        end
        crc_done = 1'b0;

        for (int j = 0; j < FB; j++) push(8'($urandom));
        wait_start();
        take_frame(e);
        shift_bits(e, 0, FBITS, 5);
        finish_frame(16'($urandom), 2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
